// File: rtl/otp_pkg.sv
// Shared types and constants for the round-robin OTP serializer scheduler.
package otp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int MAX_NREQ       = 8;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W_MAX = grant_w(MAX_NREQ);

  function automatic logic [2:0] byte_cnt_inc(input logic [2:0] cnt);
    return (cnt >= 3'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/otp_serializer_sched_if.sv
// Requester and serializer signals of the OTP scheduler; master = scheduler side.
interface otp_serializer_sched_if
  import otp_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32
);
  localparam int GW = grant_w(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] word_in;
  logic [NREQ-1:0]        ack;
  logic [GW-1:0]          grant_id;
  logic                   busy;
  logic                   ser_hold;
  logic [WORD_W-1:0]      ser_word;
  logic                   ser_cmp;
  logic                   ser_done;
  logic [2:0]             byte_cnt;
  logic                   err;

  modport master (
    input  req, word_in, ser_cmp, ser_done,
    output ack, grant_id, busy, ser_hold, ser_word, byte_cnt, err
  );

  modport slave (
    output req, word_in, ser_cmp, ser_done,
    input  ack, grant_id, busy, ser_hold, ser_word, byte_cnt, err
  );
endinterface

// File: rtl/otp_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_i, wrapping.
module otp_rr_arbiter
  import otp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = grant_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [GW-1:0]   idx_o,
  output logic            valid_o
);

  int            cand_s;
  logic [GW-1:0] cidx_s;
  logic          hit_s;

  // scan from the requester after the last winner; the first hit wins
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = 0;
    cidx_s  = '0;
    hit_s   = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_s         = (int'(last_i) + off) % NREQ;
      cidx_s         = GW'(cand_s);
      hit_s          = req_i[cidx_s] && !valid_o;
      gnt_o[cidx_s]  = gnt_o[cidx_s] | hit_s;
      idx_o          = hit_s ? cidx_s : idx_o;
      valid_o        = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/otp_serializer_sched.sv
// Round-robin scheduler sharing one 32-bit->byte OTP serializer among NREQ sources.
// Optional RUN watchdog enabled by defining OTP_SCHED_WDOG_EN.
module otp_serializer_sched
  import otp_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  otp_serializer_sched_if.master bus
);

  localparam int         GW       = grant_w(NREQ);
  localparam logic [2:0] FULL_CNT = 3'(BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [GW-1:0]     last_q, last_d, grant_q, grant_d;
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d, ack_q, ack_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        cnt_q, cnt_d, cnt_inc_s;
  logic              err_q, err_d, busy_q, busy_d, hold_q, hold_d;
  logic [NREQ-1:0]   arb_gnt_s;
  logic [GW-1:0]     arb_idx_s;
  logic              arb_valid_s, timeout_s, short_job_s;

  otp_rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req_i   (bus.req),
    .last_i  (last_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

`ifdef OTP_SCHED_WDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;

  // count RUN cycles since LOAD
  always_comb begin
    case (state_q)
      LOAD:    wd_d = '0;
      RUN:     wd_d = wd_q + TW'(1);
      default: wd_d = wd_q;
    endcase
  end

  // watchdog counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign timeout_s = (state_q == RUN) && !bus.ser_done && (wd_q == TW'(TIMEOUT - 1));
`else
  // no watchdog in this build: RUN only ends on ser_done
  assign timeout_s = (TIMEOUT < 0);
`endif

  assign cnt_inc_s   = bus.ser_cmp ? byte_cnt_inc(cnt_q) : cnt_q;
  assign short_job_s = bus.ser_done && (cnt_inc_s != FULL_CNT);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    case (state_q)
      IDLE:    state_d = arb_valid_s ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = (bus.ser_done || timeout_s) ? DRAIN : RUN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs and job context
  always_comb begin
    last_d   = last_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ack_d    = '0;
    busy_d   = (state_d != IDLE);
    hold_d   = (state_d == IDLE) || (state_d == DRAIN);
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          grant_d  = arb_idx_s;
          gnt_oh_d = arb_gnt_s;
          word_d   = bus.word_in[int'(arb_idx_s)*WORD_W +: WORD_W];
          cnt_d    = 3'd0;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      LOAD: cnt_d = cnt_q;
      RUN: begin
        cnt_d = cnt_inc_s;
        if (short_job_s || timeout_s) err_d = 1'b1;
        else                          err_d = err_q;
        if (state_d == DRAIN) ack_d = gnt_oh_q;
        else                  ack_d = '0;
      end
      DRAIN:   last_d = grant_q;
      default: last_d = last_q;
    endcase
  end

  // output and context registers; last_grant resets to NREQ-1 so req[0] wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= GW'(NREQ - 1);
      grant_q  <= GW'(NREQ - 1);
      gnt_oh_q <= '0;
      word_q   <= '0;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      last_q   <= last_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.ser_hold = hold_q;
  assign bus.ser_word = word_q;
  assign bus.byte_cnt = cnt_q;
  assign bus.err      = err_q;

endmodule
